// File: rtl/fp_div_pkg.sv
// Shared constants and types for the sequential mantissa divider.
// Both the divider top and its handshake interface import this package.
package fp_div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int CNT_WIDTH  = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_div32_if.sv
// Start/busy/done handshake and operand/result bus for seq_div32.
// The requester (master) drives start and operands; the divider (slave) drives status and results.
interface seq_div32_if
    import fp_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    // start is sampled only while the divider is idle; a start seen while busy is dropped.
    // done pulses for one cycle; quotient/remainder/div_by_zero stay valid until the next accepted start.
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/cla_sub.sv
// W-bit Kogge-Stone prefix-tree subtractor: diff = a - b, no_borrow = carry-out of a + ~b + 1.
// Purely combinational; the carry-in of 1 is folded into the bit-0 generate term.
module cla_sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         no_borrow_o
);

    localparam int LVL = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0] bn;
    logic [W-1:0] p;
    logic [W-1:0] g_pre;
    logic [W-1:0] p_pre;
    logic [W-1:0] g_nxt;
    logic [W-1:0] p_nxt;
    logic [W-1:0] carry;

    assign bn = ~b_i;
    assign p  = a_i ^ bn;

    always_comb begin
        g_pre    = a_i & bn;
        g_pre[0] = g_pre[0] | p[0];
        p_pre    = p;
        g_nxt    = '0;
        p_nxt    = '0;
        for (int l = 0; l < LVL; l++) begin
            g_nxt = g_pre;
            p_nxt = p_pre;
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << l)) begin
                    g_nxt[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << l)]);
                    p_nxt[i] = p_pre[i] & p_pre[i - (1 << l)];
                end
            end
            g_pre = g_nxt;
            p_pre = p_nxt;
        end
        // After the tree, g_pre[i] is the carry out of bit i including the carry-in.
        carry = {g_pre[W-2:0], 1'b1};
    end

    assign diff_o      = p ^ carry;
    assign no_borrow_o = g_pre[W-1];

endmodule

// File: rtl/seq_div32.sv
// Sequential unsigned restoring divider: one trial subtraction and one quotient bit per cycle.
// A zero divisor skips the iteration and reports all-ones quotient with the dividend as remainder.
module seq_div32
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    seq_div32_if.slave  div_if,
    output state_e      state_o
);

    localparam int W = DIV_WIDTH;

    state_e               state_q, state_d;
    logic [W:0]           r_q, r_d;
    logic [W-1:0]         q_q, q_d;
    logic [W-1:0]         d_q, d_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         quot_q, quot_d;
    logic [W-1:0]         rem_q, rem_d;
    logic                 dbz_q, dbz_d;

    logic [W:0]           r_shift;
    logic [W:0]           trial;
    logic                 no_borrow;
    logic [W:0]           r_step;
    logic [W-1:0]         q_step;
    logic                 last_step;
    logic                 accept;
    logic                 unused_r_msb;

    // Partial remainder stays below the divisor, so its top bit never reaches the shift.
    assign r_shift      = {r_q[W-1:0], q_q[W-1]};
    assign unused_r_msb = r_q[W];

    cla_sub #(.W(W + 1)) u_sub (
        .a_i         (r_shift),
        .b_i         ({1'b0, d_q}),
        .diff_o      (trial),
        .no_borrow_o (no_borrow)
    );

    assign r_step    = no_borrow ? trial : r_shift;
    assign q_step    = {q_q[W-2:0], no_borrow};
    assign last_step = (cnt_q == CNT_WIDTH'(1));
    assign accept    = (state_q == IDLE) && div_if.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    state_d = (div_if.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            if (div_if.divisor == '0) begin
                quot_d = '1;
                rem_d  = div_if.dividend;
                dbz_d  = 1'b1;
            end else begin
                q_d   = div_if.dividend;
                d_d   = div_if.divisor;
                r_d   = '0;
                cnt_d = CNT_WIDTH'(W);
                dbz_d = 1'b0;
            end
        end else if (state_q == RUN) begin
            r_d   = r_step;
            q_d   = q_step;
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (last_step) begin
                quot_d = q_step;
                rem_d  = r_step[W-1:0];
            end
        end
    end

    always_comb begin
        div_if.busy        = (state_q != IDLE);
        div_if.done        = (state_q == DONE);
        div_if.quotient    = quot_q;
        div_if.remainder   = rem_q;
        div_if.div_by_zero = dbz_q;
        state_o            = state_q;
    end

endmodule

// File: tb/tb_seq_div32.sv
// Directed and random checks of seq_div32: latency, results, zero divisor, ignored starts and reset abort.
module tb_seq_div32;
    import fp_div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic   clk;
    logic   rst;
    state_e state_o;

    int n_checks;
    int n_errors;

    logic [W-1:0] exp_q[$];

    seq_div32_if div_if ();

    seq_div32 dut (
        .clk     (clk),
        .rst     (rst),
        .div_if  (div_if),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start in the cycle after the caller's current one, then waits for done.
    // Leaves the caller #1 after the edge that starts the done cycle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int busy_cycles, output bit got_done);
        @(posedge clk); #1;
        div_if.start    = 1'b1;
        div_if.dividend = a;
        div_if.divisor  = b;
        @(posedge clk); #1;
        div_if.start = 1'b0;
        lat          = 1;
        busy_cycles  = 0;
        got_done     = 1'b0;
        while (lat < 100) begin
            if (div_if.busy) busy_cycles++;
            if (div_if.done) begin
                got_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        div_if.start = 1'b0;
        div_if.dividend = '0;
        div_if.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (div_if.busy !== 1'b0 || div_if.done !== 1'b0 || div_if.div_by_zero !== 1'b0 ||
            div_if.quotient !== '0 || div_if.remainder !== '0 || state_o !== IDLE) begin
            n_errors++;
            $display("FAIL reset_values: busy=%b done=%b dbz=%b q=%h r=%h st=%0d, required all 0 / IDLE",
                     div_if.busy, div_if.done, div_if.div_by_zero, div_if.quotient, div_if.remainder, state_o);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        bit ok;
        run_div(32'd100, 32'd7, lat, bc, ok);
        n_checks++;
        if (!ok || lat !== 33) begin
            n_errors++;
            $display("FAIL basic_latency: got_done=%0d latency=%0d, required done at 33", ok, lat);
        end
        n_checks++;
        if (bc !== 33) begin
            n_errors++;
            $display("FAIL basic_busy: busy cycles=%0d, required 33", bc);
        end
        n_checks++;
        if (div_if.quotient !== 32'd14 || div_if.remainder !== 32'd2 || div_if.div_by_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b, required q=14 r=2 dbz=0",
                     div_if.quotient, div_if.remainder, div_if.div_by_zero);
        end
        @(posedge clk); #1;
        n_checks++;
        if (div_if.busy !== 1'b0 || div_if.done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_after_done: busy=%b done=%b, required 0 0", div_if.busy, div_if.done);
        end
    endtask

    task automatic test_wide();
        int lat, bc;
        bit ok;
        run_div(32'hFFFF_FFFF, 32'h8000_0000, lat, bc, ok);
        n_checks++;
        if (!ok || div_if.quotient !== 32'd1 || div_if.remainder !== 32'h7FFF_FFFF) begin
            n_errors++;
            $display("FAIL wide_msb_divisor: done=%0d q=%h r=%h, required q=00000001 r=7fffffff",
                     ok, div_if.quotient, div_if.remainder);
        end
        run_div(32'hFFFF_FFFF, 32'd1, lat, bc, ok);
        n_checks++;
        if (!ok || div_if.quotient !== 32'hFFFF_FFFF || div_if.remainder !== 32'd0) begin
            n_errors++;
            $display("FAIL wide_div_by_one: done=%0d q=%h r=%h, required q=ffffffff r=0",
                     ok, div_if.quotient, div_if.remainder);
        end
    endtask

    // The zero-divisor case enters DONE directly from the accepting edge, so done is
    // seen in the very next cycle; 9/3 is then started in the first IDLE cycle after it.
    task automatic test_div_zero_back_to_back();
        int lat, bc;
        bit ok;
        run_div(32'd5, 32'd0, lat, bc, ok);
        n_checks++;
        if (!ok || lat !== 1) begin
            n_errors++;
            $display("FAIL dbz_latency: got_done=%0d latency=%0d, required done in next cycle", ok, lat);
        end
        n_checks++;
        if (div_if.quotient !== 32'hFFFF_FFFF || div_if.remainder !== 32'd5 || div_if.div_by_zero !== 1'b1) begin
            n_errors++;
            $display("FAIL dbz_result: q=%h r=%0d dbz=%b, required q=ffffffff r=5 dbz=1",
                     div_if.quotient, div_if.remainder, div_if.div_by_zero);
        end
        run_div(32'd9, 32'd3, lat, bc, ok);
        n_checks++;
        if (!ok || lat !== 33) begin
            n_errors++;
            $display("FAIL b2b_latency: got_done=%0d latency=%0d, required 33", ok, lat);
        end
        n_checks++;
        if (div_if.quotient !== 32'd3 || div_if.remainder !== 32'd0 || div_if.div_by_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_result: q=%0d r=%0d dbz=%b, required q=3 r=0 dbz=0",
                     div_if.quotient, div_if.remainder, div_if.div_by_zero);
        end
    endtask

    task automatic test_ignored_start();
        int cyc;
        bit ok;
        logic [W-1:0] hold_q, hold_r;
        @(posedge clk); #1;
        div_if.start    = 1'b1;
        div_if.dividend = 32'd1000;
        div_if.divisor  = 32'd3;
        @(posedge clk); #1;
        div_if.start = 1'b0;
        cyc = 1;
        ok  = 1'b0;
        while (cyc < 100) begin
            if (div_if.done) begin
                ok = 1'b1;
                break;
            end
            if (cyc == 5 || cyc == 20) begin
                div_if.start    = 1'b1;
                div_if.dividend = 32'd8;
                div_if.divisor  = 32'd2;
            end else begin
                div_if.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        div_if.start = 1'b0;
        n_checks++;
        if (!ok || cyc !== 33) begin
            n_errors++;
            $display("FAIL ignore_latency: got_done=%0d latency=%0d, required 33", ok, cyc);
        end
        n_checks++;
        if (div_if.quotient !== 32'd333 || div_if.remainder !== 32'd1) begin
            n_errors++;
            $display("FAIL ignore_result: q=%0d r=%0d, required q=333 r=1", div_if.quotient, div_if.remainder);
        end
        hold_q = div_if.quotient;
        hold_r = div_if.remainder;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (div_if.quotient !== 32'd333 || div_if.remainder !== 32'd1 || div_if.busy !== 1'b0 ||
                div_if.done !== 1'b0 || hold_q !== 32'd333 || hold_r !== 32'd1) begin
                n_errors++;
                $display("FAIL idle_hold[%0d]: q=%0d r=%0d busy=%b done=%b, required 333 1 0 0",
                         i, div_if.quotient, div_if.remainder, div_if.busy, div_if.done);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        bit ok;
        bit saw_done;
        @(posedge clk); #1;
        div_if.start    = 1'b1;
        div_if.dividend = 32'hDEAD_BEEF;
        div_if.divisor  = 32'h0000_1234;
        @(posedge clk); #1;
        div_if.start = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (div_if.busy !== 1'b0 || div_if.done !== 1'b0 || div_if.div_by_zero !== 1'b0 ||
            div_if.quotient !== '0 || div_if.remainder !== '0 || state_o !== IDLE) begin
            n_errors++;
            $display("FAIL abort_reset: busy=%b done=%b dbz=%b q=%h r=%h st=%0d, required all 0 / IDLE",
                     div_if.busy, div_if.done, div_if.div_by_zero, div_if.quotient, div_if.remainder, state_o);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_if.done || div_if.busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_no_done: activity=%0d after abort, required 0", saw_done);
        end
        // rst asserted together with start: the start must not be accepted.
        rst             = 1'b1;
        div_if.start    = 1'b1;
        div_if.dividend = 32'd77;
        div_if.divisor  = 32'd7;
        @(posedge clk); #1;
        rst          = 1'b0;
        div_if.start = 1'b0;
        n_checks++;
        if (div_if.busy !== 1'b0 || state_o !== IDLE) begin
            n_errors++;
            $display("FAIL rst_vs_start: busy=%b st=%0d, required 0 / IDLE", div_if.busy, state_o);
        end
        run_div(32'hDEAD_BEEF, 32'h0000_1234, lat, bc, ok);
        n_checks++;
        if (!ok || div_if.quotient !== 32'h000C_3BA5 || div_if.remainder !== 32'h0000_076B) begin
            n_errors++;
            $display("FAIL abort_restart: done=%0d q=%h r=%h, required q=000c3ba5 r=0000076b",
                     ok, div_if.quotient, div_if.remainder);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        bit ok;
        logic [W-1:0] a, b, eq, er;
        logic [63:0]  recon;
        for (int i = 0; i < 2000; i++) begin
            a = $urandom();
            b = $urandom() >> $urandom_range(0, 31);
            if (i % 10 == 0) a = '0;
            if (i % 10 == 1) begin
                a = $urandom_range(0, 1000);
                b = a + 32'd1 + $urandom_range(0, 100);
            end
            if (b == '0) b = 32'd1;
            exp_q.push_back(a / b);
            exp_q.push_back(a % b);
            run_div(a, b, lat, bc, ok);
            eq = exp_q.pop_front();
            er = exp_q.pop_front();
            recon = 64'(div_if.quotient) * 64'(b) + 64'(div_if.remainder);
            n_checks++;
            if (!ok || lat !== 33 || div_if.quotient !== eq || div_if.remainder !== er ||
                recon !== 64'(a) || div_if.remainder >= b) begin
                n_errors++;
                $display("FAIL random[%0d]: %h/%h done=%0d lat=%0d q=%h r=%h, required q=%h r=%h lat=33",
                         i, a, b, ok, lat, div_if.quotient, div_if.remainder, eq, er);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_wide();
        test_div_zero_back_to_back();
        test_ignored_start();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
